bk_mpadd_seq: RTL and testbench
===============================

// Module: bk_mpadd_seq
// PURPOSE
// Multi-precision add/subtract sequencer wrapped around the 16-bit Brentkung_adder datapath.
// - Accepts operands as a stream of 16-bit words, least-significant word first.
// - Chains the carry between words and returns one registered result word per input word.
// - Sits directly around the adder: drives X/Y/Cin from its input stream and registers SUM/Cout onto its output stream.
// PARAMETERS
// MAX_WORDS  8  maximum words per operand; the word counter is $clog2(MAX_WORDS+1) bits
// PORTS
// clk        in   1   clock; all state updates on the rising edge
// rst        in   1   synchronous reset, active-high
// in_valid   in   1   input word present
// in_ready   out  1   sequencer can accept an input word this cycle
// in_a       in   16  operand A word
// in_b       in   16  operand B word
// in_first   in   1   word is the LS word of a new operand; starts a new carry chain
// in_last    in   1   word is the MS word of the operand
// op_sub     in   1   1 = A-B, 0 = A+B; sampled only on the first word
// out_valid  out  1   result word present
// out_ready  in   1   downstream accepts the result word
// out_sum    out  16  result word
// out_last   out  1   result word is the MS word of the operand
// out_cout   out  1   carry out of the MS word; valid only when out_last=1, else 0
// out_ovf    out  1   signed overflow of the full-width result; valid only when out_last=1, else 0
// out_err    out  1   framing error attached to this word
// BEHAVIOUR
// - Reset: out_valid, out_sum, out_last, out_cout, out_ovf, out_err, carry_q, word count and op_sub_q are 0.
//   After reset the FSM is IDLE and in_ready=1.
// - Handshakes:
//   - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
//   - in_ready = !out_valid | out_ready. This is a single output register with no bubble.
//   - While out_valid=1 and out_ready=0, all out_* signals hold stable.
// - Datapath per accepted word:
//   - X = in_a.
//   - Y = sub ? ~in_b : in_b, where sub = in_first ? op_sub : op_sub_q.
//   - Cin = in_first ? op_sub : carry_q.
//   - On acceptance: out_sum <= SUM and carry_q <= Cout.
//   - If in_first, op_sub_q <= op_sub.
// - Latency: 1 cycle from the accepting edge to out_valid=1 carrying that word's result. Full throughput is 1 word/cycle.
// - Overflow: out_ovf = (X[15] == Y[15]) & (SUM[15] != X[15]), evaluated on the last word only.
// - Subtract: out_cout = 1 means no borrow.
// - FSM:
//   - IDLE: wait for the first word.
//     - Accept with in_first=1: go to IDLE if in_last, else to BUSY; count=1.
//     - Accept with in_first=0: still processed as a first word (carry = op_sub); out_err=1 on that word.
//   - BUSY: chain carry, count++.
//     - Accept with in_last=1: go to IDLE.
//     - Accept with in_first=1: the chain restarts as a first word; out_err=1 on that word; count=1.
// - MAX_WORDS boundary: if count reaches MAX_WORDS without in_last:
//   - that word is emitted with out_last=1 and out_err=1 (cout/ovf computed normally);
//   - FSM goes to IDLE.
// - A word carrying both in_first and in_last is a complete single-word operation.
// - Reset mid-operand: partial chain discarded, any held output word dropped (out_valid=0), FSM to IDLE.
// - No combinational path from out_ready to out_* (in_ready does depend on out_ready).
// TESTING
// - 1-word add: A=0x7FFF, B=0x0001, first=last=1, sub=0 -> sum=0x8000, cout=0, ovf=1, last=1, err=0.
// - 1-word sub: A=0x0005, B=0x0007, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0.
// - 2-word add of 0x0000FFFF + 0x00000001:
//   - words (FFFF,0001) first, then (0000,0000) last -> out 0x0000 then 0x0001, cout=0, ovf=0.
// - Backpressure: stream 3 words with out_ready low for 2 cycles mid-stream:
//   - in_ready=0 while the output is held; no word lost or duplicated;
//   - result of 0x0001_FFFF_FFFF + 0x0000_0000_0001 = 0x0002_0000_0000.
// - Framing: 8 words, none with in_last -> 8th output has last=1, err=1; next first word starts clean.
// - Reset mid-operand after word 2 of 4 -> out_valid=0 next cycle; a new single-word add 3+4 -> sum=0x0007, err=0.

Source files
------------

// File: rtl/bk_mpadd_seq.sv
// ---------------------------------------------------------------------------
// bk_mpadd_seq : multi-precision add/subtract sequencer around a 16-bit
//                Brent-Kung adder, one registered result word per input word.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bk_mpadd_seq #(
  parameter int MAX_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_first,
  input  logic        in_last,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_last,
  output logic        out_cout,
  output logic        out_ovf,
  output logic        out_err
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic          carry_q;
  logic          op_sub_q;

  // Brent-Kung prefix adder; cin is folded into bit 0 so the prefix G is the carry.
  function automatic logic [16:0] bk_add(input logic [15:0] x, input logic [15:0] y,
                                         input logic cin);
    logic [15:0] p, gg, pp;
    logic [16:0] c;
    p     = x ^ y;
    gg    = x & y;
    gg[0] = gg[0] | (p[0] & cin);
    pp    = p;
    for (int l = 0; l < 4; l++) begin
      for (int i = (2 << l) - 1; i < 16; i += (2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end
    for (int l = 2; l >= 0; l--) begin
      for (int i = (3 << l) - 1; i < 16; i += (2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
      end
    end
    c = {gg, cin};
    return {c[16], p ^ c[15:0]};
  endfunction

  logic          accept;
  logic          treat_first;
  logic          frame_err;
  logic          sub;
  logic [15:0]   y;
  logic          cin;
  logic [16:0]   add_res;
  logic [CW-1:0] next_count;
  logic          hit_max;
  logic          eff_last;
  logic          ovf;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // A word seen in IDLE always opens a chain; a first word in BUSY restarts it.
  assign treat_first = (state == IDLE) | in_first;
  assign frame_err   = (state == IDLE) ? !in_first : in_first;
  assign sub         = treat_first ? op_sub : op_sub_q;
  assign y           = sub ? ~in_b : in_b;
  assign cin         = treat_first ? op_sub : carry_q;
  assign add_res     = bk_add(in_a, y, cin);
  assign next_count  = treat_first ? CW'(1) : count + CW'(1);
  assign hit_max     = !in_last && (next_count == CW'(MAX_WORDS));
  assign eff_last    = in_last | hit_max;
  assign ovf         = (in_a[15] == y[15]) & (add_res[15] != in_a[15]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      carry_q   <= 1'b0;
      op_sub_q  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= add_res[15:0];
      out_last  <= eff_last;
      out_cout  <= eff_last & add_res[16];
      out_ovf   <= eff_last & ovf;
      out_err   <= frame_err | hit_max;
      carry_q   <= add_res[16];
      count     <= next_count;
      if (treat_first) begin
        op_sub_q <= op_sub;
      end
      state     <= eff_last ? IDLE : BUSY;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bk_mpadd_seq.sv
// Testbench for bk_mpadd_seq: directed scenarios plus randomized operands
// checked against a wide-integer reference model through an expected-word queue.
`default_nettype none

module tb_bk_mpadd_seq;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_first;
  logic        in_last;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_last;
  logic        out_cout;
  logic        out_ovf;
  logic        out_err;

  bk_mpadd_seq #(.MAX_WORDS(MW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_last(out_last), .out_cout(out_cout),
    .out_ovf(out_ovf), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic        last;
    logic        cout;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   stall_cnt = 0;
  bit   rand_ready = 1'b0;

  // Scoreboard: every output transfer must match the oldest expected word.
  exp_t e;
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got sum=%h last=%b, no word expected", out_sum, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_sum, out_last, out_cout, out_ovf, out_err} !== {e.sum, e.last, e.cout, e.ovf, e.err}) begin
          n_fail++;
          $display("FAIL out_word: got sum=%h last=%b cout=%b ovf=%b err=%b, expected sum=%h last=%b cout=%b ovf=%b err=%b",
                   out_sum, out_last, out_cout, out_ovf, out_err, e.sum, e.last, e.cout, e.ovf, e.err);
        end
      end
    end
  end

  task automatic expect_word(input logic [15:0] s, input logic l, input logic c,
                             input logic o, input logic er);
    exp_t w;
    w.sum = s; w.last = l; w.cout = c; w.ovf = o; w.err = er;
    exp_q.push_back(w);
  endtask

  // Reference: whole operands as one wide integer.
  task automatic model_op(input int n, input logic [15:0] a [MW], input logic [15:0] b [MW],
                          input logic sub, input bit report_last, input bit err_first,
                          input bit err_final);
    logic [143:0] xa, yb, res;
    logic co, ov, lw;
    xa = '0; yb = '0;
    for (int i = 0; i < n; i++) begin
      xa[16*i +: 16] = a[i];
      yb[16*i +: 16] = sub ? ~b[i] : b[i];
    end
    res = xa + yb + {143'd0, sub};
    co  = res[16*n];
    ov  = (xa[16*n-1] == yb[16*n-1]) && (res[16*n-1] != xa[16*n-1]);
    for (int i = 0; i < n; i++) begin
      lw = (i == n - 1) && report_last;
      expect_word(res[16*i +: 16], lw, lw ? co : 1'b0, lw ? ov : 1'b0,
                  (i == 0 && err_first) || (i == n - 1 && err_final));
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic f,
                      input logic l, input logic s);
    bit acc;
    int waitc = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_first = f; in_last = l; op_sub = s;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    forever begin
      #1;
      acc = in_ready;
      @(posedge clk);
      if (acc) break;
      stall_cnt++;
      waitc++;
      if (waitc > 50) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: got no acceptance in %0d cycles, required acceptance", waitc);
        break;
      end
      @(negedge clk);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic drain();
    int k = 0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #3;
    while ((exp_q.size() != 0 || out_valid) && k < 40) begin
      @(negedge clk);
      #3;
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got %0d words outstanding, out_valid=%b, required 0 and 0",
               exp_q.size(), out_valid);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    n_checks += 7;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    if (in_ready  !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    if (out_sum !== 16'h0)  begin n_fail++; $display("FAIL rst_out_sum: got %h, required 0000", out_sum); end
    if (out_last  !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b, required 0", out_last); end
    if (out_cout  !== 1'b0) begin n_fail++; $display("FAIL rst_out_cout: got %b, required 0", out_cout); end
    if (out_ovf   !== 1'b0) begin n_fail++; $display("FAIL rst_out_ovf: got %b, required 0", out_ovf); end
    if (out_err   !== 1'b0) begin n_fail++; $display("FAIL rst_out_err: got %b, required 0", out_err); end
  endtask

  task automatic test_directed();
    rand_ready = 1'b0;
    expect_word(16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b1, 1'b1, 1'b0);
    expect_word(16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    expect_word(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_word(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
    send(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] a [MW];
    logic [15:0] b [MW];
    rand_ready = 1'b0;
    stall_cnt = 0;
    for (int i = 0; i < MW; i++) begin a[i] = 16'hFFFF; b[i] = 16'($urandom); end
    b[0] = 16'h0001;
    model_op(4, a, b, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(a[i], b[i], i == 0, i == 3, 1'b0);
    n_checks++;
    if (stall_cnt != 0) begin
      n_fail++;
      $display("FAIL back_to_back_stalls: got %0d stall cycles, required 0", stall_cnt);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    rand_ready = 1'b0;
    expect_word(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_word(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_word(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0000; in_first = 1'b0; in_last = 1'b1;
    out_ready = 1'b0;
    #1;
    held = out_sum;
    n_checks += 3;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_c1: got %b, required 0", in_ready); end
    @(negedge clk);
    #1;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_c2: got %b, required 0", in_ready); end
    if (out_valid !== 1'b1 || out_sum !== held) begin
      n_fail++;
      $display("FAIL bp_hold: got valid=%b sum=%h, required valid=1 sum=%h", out_valid, out_sum, held);
    end
    send(16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_framing();
    logic [15:0] a [MW];
    logic [15:0] b [MW];
    rand_ready = 1'b0;
    for (int i = 0; i < MW; i++) begin a[i] = 16'($urandom); b[i] = 16'($urandom); end
    model_op(MW, a, b, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < MW; i++) send(a[i], b[i], i == 0, 1'b0, 1'b0);
    expect_word(16'h0007, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'h0003, 16'h0004, 1'b1, 1'b1, 1'b0);
    // Word without in_first while idle.
    expect_word(16'h1235, 1'b1, 1'b0, 1'b0, 1'b1);
    send(16'h1234, 16'h0001, 1'b0, 1'b1, 1'b0);
    // in_first in the middle of a chain restarts it.
    expect_word(16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_word(16'h0100, 1'b1, 1'b0, 1'b0, 1'b1);
    send(16'h0010, 16'h0020, 1'b1, 1'b0, 1'b0);
    send(16'h00FF, 16'h0001, 1'b1, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_reset_mid();
    rand_ready = 1'b0;
    expect_word(16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0);
    send(16'h4444, 16'h5555, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #3;
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b, required 0", out_valid); end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_pending: got %0d words outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    expect_word(16'h0007, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'h0003, 16'h0004, 1'b1, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_random();
    logic [15:0] a [MW];
    logic [15:0] b [MW];
    int n;
    logic sub;
    rand_ready = 1'b1;
    for (int op = 0; op < 30; op++) begin
      n   = $urandom_range(1, MW);
      sub = 1'($urandom_range(0, 1));
      for (int i = 0; i < MW; i++) begin
        a[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        b[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      end
      model_op(n, a, b, sub, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < n; i++)
        send(a[i], b[i], i == 0, i == n - 1, (i == 0) ? sub : 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_first = 1'b0; in_last = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_framing();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
